// File: rtl/bt656cap_bufsched_if.sv
// Signal bundle between the capture control registers / FML burst writer and the
// frame-buffer ring scheduler.
interface bt656cap_bufsched_if #(
  parameter int fml_depth = 27
);
  logic                 enable;
  logic                 base_we;
  logic [2:0]           base_idx;
  logic [fml_depth-6:0] base_adr;
  logic [14:0]          max_bursts;
  logic                 start_of_frame;
  logic                 next_burst;
  logic [fml_depth-6:0] fml_adr_base;
  logic                 capture_en;
  logic                 last_burst;
  // Ready queue handshake: rdy_idx/rdy_bursts are meaningful only while rdy_valid
  // is high; the head is consumed on any rising clock edge where rdy_valid and
  // rdy_pop are both high, and rdy_pop without rdy_valid has no effect.
  logic                 rdy_valid;
  logic [2:0]           rdy_idx;
  logic [14:0]          rdy_bursts;
  logic                 rdy_pop;
  logic                 rel_we;
  logic [2:0]           rel_idx;
  logic                 irq;
  logic [15:0]          dropped;

  modport master (
    output enable, base_we, base_idx, base_adr, max_bursts, start_of_frame,
           next_burst, rdy_pop, rel_we, rel_idx,
    input  fml_adr_base, capture_en, last_burst, rdy_valid, rdy_idx,
           rdy_bursts, irq, dropped
  );

  modport slave (
    input  enable, base_we, base_idx, base_adr, max_bursts, start_of_frame,
           next_burst, rdy_pop, rel_we, rel_idx,
    output fml_adr_base, capture_en, last_burst, rdy_valid, rdy_idx,
           rdy_bursts, irq, dropped
  );
endinterface

// File: rtl/bt656cap_bufsched.sv
// Frame-buffer ring scheduler: hands free buffers to the capture DMA, counts
// bursts, queues finished frames to software and reclaims released buffers.
module bt656cap_bufsched #(
  parameter int fml_depth = 27,
  parameter int nbuf      = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  bt656cap_bufsched_if.slave   bus,
  output logic [1:0]           state_dbg
);
  localparam int aw = fml_depth - 5;
  localparam logic [3:0] nbuf_l = 4'(nbuf);
  localparam logic [2:0] last_ptr = 3'(nbuf - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2
  } state_t;

  localparam logic [1:0] B_FREE    = 2'd0;
  localparam logic [1:0] B_FILLING = 2'd1;
  localparam logic [1:0] B_READY   = 2'd2;
  localparam logic [1:0] B_OWNED   = 2'd3;

  // Arrays are sized for the largest ring so 3-bit indices address them directly;
  // entries at or above nbuf are never allocated or written.
  state_t          state;
  logic [1:0]      buf_st   [8];
  logic [aw-1:0]   base_mem [8];
  logic [2:0]      fifo_idx [8];
  logic [14:0]     fifo_cnt [8];
  logic [2:0]      rr, cur_idx, wr_ptr, rd_ptr;
  logic [3:0]      fifo_count;
  logic [14:0]     counter;
  logic [aw-1:0]   fml_adr_base_q;
  logic            capture_en_q, last_burst_q, irq_q;
  logic [15:0]     dropped_q;

  logic            alloc_found;
  logic [2:0]      alloc_idx;
  logic            frame_ok, do_push, do_pop, drop_event;

  function automatic logic [2:0] wrap_idx(input int v);
    return (v >= nbuf) ? 3'(v - nbuf) : 3'(v);
  endfunction

  function automatic logic [2:0] next_ptr(input logic [2:0] p);
    return (p == last_ptr) ? 3'd0 : p + 3'd1;
  endfunction

  // Round-robin search; the buffer being closed is still FILLING, so it is skipped.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = 3'd0;
    for (int k = nbuf - 1; k >= 0; k--) begin
      if (buf_st[wrap_idx(int'(rr) + k)] == B_FREE) begin
        alloc_found = 1'b1;
        alloc_idx   = wrap_idx(int'(rr) + k);
      end
    end
  end

  always_comb begin
    frame_ok   = (counter == bus.max_bursts);
    do_push    = bus.enable && (state == CAPTURE) && bus.start_of_frame && frame_ok;
    do_pop     = bus.rdy_pop && (fifo_count != 4'd0);
    drop_event = bus.enable && bus.start_of_frame &&
                 (((state == WAIT_SOF) && !alloc_found) ||
                  ((state == CAPTURE) && !frame_ok));
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= IDLE;
      rr             <= 3'd0;
      cur_idx        <= 3'd0;
      wr_ptr         <= 3'd0;
      rd_ptr         <= 3'd0;
      fifo_count     <= 4'd0;
      counter        <= 15'd0;
      fml_adr_base_q <= '0;
      capture_en_q   <= 1'b0;
      last_burst_q   <= 1'b0;
      irq_q          <= 1'b0;
      dropped_q      <= 16'd0;
      for (int i = 0; i < 8; i++) begin
        buf_st[i]   <= B_FREE;
        base_mem[i] <= '0;
        fifo_idx[i] <= 3'd0;
        fifo_cnt[i] <= 15'd0;
      end
    end else begin
      irq_q <= do_push;

      if (bus.base_we && ({1'b0, bus.base_idx} < nbuf_l))
        base_mem[bus.base_idx] <= bus.base_adr;

      if (bus.rel_we && ({1'b0, bus.rel_idx} < nbuf_l) && (buf_st[bus.rel_idx] == B_OWNED))
        buf_st[bus.rel_idx] <= B_FREE;

      if (do_pop) begin
        buf_st[fifo_idx[rd_ptr]] <= B_OWNED;
        rd_ptr                   <= next_ptr(rd_ptr);
      end

      if (do_push) begin
        fifo_idx[wr_ptr] <= cur_idx;
        fifo_cnt[wr_ptr] <= counter;
        wr_ptr           <= next_ptr(wr_ptr);
      end

      case ({do_push, do_pop})
        2'b10:   fifo_count <= fifo_count + 4'd1;
        2'b01:   fifo_count <= fifo_count - 4'd1;
        default: fifo_count <= fifo_count;
      endcase

      if (drop_event && (dropped_q != 16'hffff))
        dropped_q <= dropped_q + 16'd1;

      if (!bus.enable) begin
        if (state == CAPTURE)
          buf_st[cur_idx] <= B_FREE;
        capture_en_q <= 1'b0;
        last_burst_q <= 1'b0;
        state        <= IDLE;
      end else begin
        case (state)
          IDLE: state <= WAIT_SOF;

          WAIT_SOF: begin
            if (bus.start_of_frame && alloc_found) begin
              buf_st[alloc_idx] <= B_FILLING;
              cur_idx           <= alloc_idx;
              rr                <= next_ptr(alloc_idx);
              fml_adr_base_q    <= base_mem[alloc_idx];
              counter           <= 15'd0;
              capture_en_q      <= 1'b1;
              last_burst_q      <= (bus.max_bursts == 15'd1);
              state             <= CAPTURE;
            end
          end

          CAPTURE: begin
            if (bus.start_of_frame) begin
              buf_st[cur_idx] <= frame_ok ? B_READY : B_FREE;
              if (alloc_found) begin
                buf_st[alloc_idx] <= B_FILLING;
                cur_idx           <= alloc_idx;
                rr                <= next_ptr(alloc_idx);
                fml_adr_base_q    <= base_mem[alloc_idx];
                counter           <= 15'd0;
                capture_en_q      <= 1'b1;
                last_burst_q      <= (bus.max_bursts == 15'd1);
              end else begin
                capture_en_q <= 1'b0;
                last_burst_q <= 1'b0;
                state        <= WAIT_SOF;
              end
            end else if (bus.next_burst && (counter < bus.max_bursts)) begin
              counter <= counter + 15'd1;
              if ((counter + 15'd1) == bus.max_bursts) begin
                capture_en_q <= 1'b0;
                last_burst_q <= 1'b0;
              end else begin
                last_burst_q <= (({1'b0, counter} + 16'd2) == {1'b0, bus.max_bursts});
              end
            end else if (counter >= bus.max_bursts) begin
              // max_bursts may shrink under a running frame
              capture_en_q <= 1'b0;
              last_burst_q <= 1'b0;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.fml_adr_base = fml_adr_base_q;
  assign bus.capture_en   = capture_en_q;
  assign bus.last_burst   = last_burst_q;
  assign bus.rdy_valid    = (fifo_count != 4'd0);
  assign bus.rdy_idx      = fifo_idx[rd_ptr];
  assign bus.rdy_bursts   = fifo_cnt[rd_ptr];
  assign bus.irq          = irq_q;
  assign bus.dropped      = dropped_q;
  assign state_dbg        = state;
endmodule

// File: tb/tb_bt656cap_bufsched.sv
// Directed bench for the BT.656 capture buffer scheduler (nbuf=4, max_bursts=3).
module tb_bt656cap_bufsched;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [1:0] state_dbg;
  int         n_checks = 0;
  int         n_fail = 0;

  bt656cap_bufsched_if #(.fml_depth(27)) bus ();

  bt656cap_bufsched #(.fml_depth(27), .nbuf(4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  // driver tasks
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic sof();
    bus.start_of_frame = 1'b1;
    step();
    bus.start_of_frame = 1'b0;
  endtask

  task automatic bursts(input int n);
    for (int i = 0; i < n; i++) begin
      bus.next_burst = 1'b1;
      step();
      bus.next_burst = 1'b0;
    end
  endtask

  task automatic pop();
    bus.rdy_pop = 1'b1;
    step();
    bus.rdy_pop = 1'b0;
  endtask

  task automatic release_buf(input logic [2:0] idx);
    bus.rel_we  = 1'b1;
    bus.rel_idx = idx;
    step();
    bus.rel_we  = 1'b0;
  endtask

  task automatic write_base(input logic [2:0] idx, input logic [21:0] adr);
    bus.base_we  = 1'b1;
    bus.base_idx = idx;
    bus.base_adr = adr;
    step();
    bus.base_we  = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.enable = 1'b0; bus.base_we = 1'b0; bus.base_idx = 3'd0; bus.base_adr = '0;
    bus.max_bursts = 15'd3; bus.start_of_frame = 1'b0; bus.next_burst = 1'b0;
    bus.rdy_pop = 1'b0; bus.rel_we = 1'b0; bus.rel_idx = 3'd0;

    // reset values
    step(); step();
    check("rst_cap_en", 32'(bus.capture_en), 0);
    check("rst_last", 32'(bus.last_burst), 0);
    check("rst_rdy_valid", 32'(bus.rdy_valid), 0);
    check("rst_irq", 32'(bus.irq), 0);
    check("rst_dropped", 32'(bus.dropped), 0);
    check("rst_base", 32'(bus.fml_adr_base), 0);
    check("rst_state", 32'(state_dbg), 0);
    sys_rst_n = 1'b1;

    write_base(3'd0, 22'h100);
    write_base(3'd1, 22'h200);
    write_base(3'd2, 22'h300);
    write_base(3'd3, 22'h400);
    write_base(3'd5, 22'h3ff);
    bus.enable = 1'b1;
    step();
    check("idle_to_wait", 32'(state_dbg), 1);

    // frame on buffer 0
    sof();
    check("f0_cap_en", 32'(bus.capture_en), 1);
    check("f0_base", 32'(bus.fml_adr_base), 32'h100);
    check("f0_last_start", 32'(bus.last_burst), 0);
    bursts(1);
    check("f0_last_b1", 32'(bus.last_burst), 0);
    bursts(1);
    check("f0_last_b2", 32'(bus.last_burst), 1);
    check("f0_cap_b2", 32'(bus.capture_en), 1);
    bursts(1);
    check("f0_last_b3", 32'(bus.last_burst), 0);
    check("f0_cap_b3", 32'(bus.capture_en), 0);
    bursts(1);
    check("f0_extra_burst", 32'(bus.capture_en), 0);
    sof();
    check("f1_irq", 32'(bus.irq), 1);
    check("f1_rdy_valid", 32'(bus.rdy_valid), 1);
    check("f1_rdy_idx", 32'(bus.rdy_idx), 0);
    check("f1_rdy_bursts", 32'(bus.rdy_bursts), 3);
    check("f1_base", 32'(bus.fml_adr_base), 32'h200);
    check("f1_cap_en", 32'(bus.capture_en), 1);
    step();
    check("f1_irq_pulse", 32'(bus.irq), 0);

    // fill the ring with no pops or releases
    bursts(3); sof();
    check("f2_base", 32'(bus.fml_adr_base), 32'h300);
    bursts(3); sof();
    check("f3_base", 32'(bus.fml_adr_base), 32'h400);
    bursts(3); sof();
    check("full_cap_en", 32'(bus.capture_en), 0);
    check("full_irq", 32'(bus.irq), 1);
    check("full_state", 32'(state_dbg), 1);
    check("full_dropped0", 32'(bus.dropped), 0);
    sof();
    check("full_dropped1", 32'(bus.dropped), 1);
    check("full_cap_en2", 32'(bus.capture_en), 0);
    check("full_head", 32'(bus.rdy_idx), 0);

    // pop + release buffer 0, then it is reallocated
    pop();
    check("pop_head", 32'(bus.rdy_idx), 1);
    release_buf(3'd0);
    sof();
    check("realloc_base", 32'(bus.fml_adr_base), 32'h100);
    check("realloc_cap_en", 32'(bus.capture_en), 1);
    write_base(3'd0, 22'h150);
    check("filling_base_kept", 32'(bus.fml_adr_base), 32'h100);

    // short frame on buffer 0; buffer 1 freed beforehand
    pop();
    release_buf(3'd1);
    bursts(2);
    sof();
    check("short_irq", 32'(bus.irq), 0);
    check("short_dropped", 32'(bus.dropped), 2);
    check("short_next_base", 32'(bus.fml_adr_base), 32'h200);
    check("short_cap_en", 32'(bus.capture_en), 1);

    // disable mid-frame
    bursts(1);
    bus.enable = 1'b0;
    step();
    check("dis_cap_en", 32'(bus.capture_en), 0);
    check("dis_state", 32'(state_dbg), 0);
    check("dis_rdy_valid", 32'(bus.rdy_valid), 1);
    check("dis_rdy_idx", 32'(bus.rdy_idx), 2);
    bus.enable = 1'b1;
    step();
    sof();
    check("after_dis_base", 32'(bus.fml_adr_base), 32'h150);

    // release coinciding with SOF while no buffer is free
    bursts(3); sof();
    check("f9_irq", 32'(bus.irq), 1);
    check("f9_base", 32'(bus.fml_adr_base), 32'h200);
    bursts(3);
    pop();
    check("f9_head", 32'(bus.rdy_idx), 3);
    sof();
    check("nofree_cap_en", 32'(bus.capture_en), 0);
    bus.rel_we = 1'b1; bus.rel_idx = 3'd2;
    sof();
    bus.rel_we = 1'b0;
    check("relsof_dropped", 32'(bus.dropped), 3);
    check("relsof_cap_en", 32'(bus.capture_en), 0);
    sof();
    check("relsof_alloc_base", 32'(bus.fml_adr_base), 32'h300);
    check("relsof_cap_en2", 32'(bus.capture_en), 1);

    // max_bursts lowered below current count
    bursts(1);
    bus.max_bursts = 15'd1;
    step();
    check("maxchg_cap_en", 32'(bus.capture_en), 0);
    bus.max_bursts = 15'd3;

    // asynchronous reset between clock edges
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("arst_base", 32'(bus.fml_adr_base), 0);
    check("arst_rdy_valid", 32'(bus.rdy_valid), 0);
    check("arst_dropped", 32'(bus.dropped), 0);
    check("arst_state", 32'(state_dbg), 0);
    #1;
    sys_rst_n = 1'b1;
    #1;
    check("arst_release_state", 32'(state_dbg), 0);
    check("arst_release_cap", 32'(bus.capture_en), 0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
